// File: rtl/alu_ctrl_pipe_if.sv
// alu_ctrl_pipe_if: ID/EX control handshake bundle between the decode stage (master) and alu_ctrl_pipe (slave).
interface alu_ctrl_pipe_if #(
    parameter int OPC_W   = 4,
    parameter int FUNCT_W = 6,
    parameter int OP_W    = 5
);
    logic               in_valid;
    logic [OPC_W-1:0]   in_opcode;
    logic [FUNCT_W-1:0] in_funct;
    logic               in_ready;
    logic               flush;
    logic               out_stall;
    logic               out_valid;
    logic [OP_W-1:0]    out_op;
    logic               out_mem_rd;
    logic               out_mem_wr;
    logic               out_illegal;
    logic               stall_req;
    logic [15:0]        perf_issued;
    logic [15:0]        perf_stalls;
    modport master (
        output in_valid, in_opcode, in_funct, flush, out_stall,
        input  in_ready, out_valid, out_op, out_mem_rd, out_mem_wr, out_illegal,
               stall_req, perf_issued, perf_stalls
    );
    modport slave (
        input  in_valid, in_opcode, in_funct, flush, out_stall,
        output in_ready, out_valid, out_op, out_mem_rd, out_mem_wr, out_illegal,
               stall_req, perf_issued, perf_stalls
    );
endinterface

// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe: registered ALU-control decoder with multi-cycle mult/div sequencing, flush and output hold.
// Define ALU_CTRL_PERF_EN to build the saturating perf_issued/perf_stalls counters.
module alu_ctrl_pipe #(
    parameter int OPC_W      = 4,
    parameter int FUNCT_W    = 6,
    parameter int OP_W       = 5,
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 3
) (
    input logic clk,
    input logic rst,
    alu_ctrl_pipe_if.slave b
);
    typedef enum logic {IDLE = 1'b0, MULTI = 1'b1} state_t;
    state_t            r_state, w_state_n;
    logic [CNT_W-1:0]  r_cnt, w_cnt_n;
    logic [OP_W-1:0]   r_op, w_op_n, r_md_op, w_md_op_n, w_dec_op;
    logic              r_valid, w_valid_n, r_rd, w_rd_n, r_wr, w_wr_n, r_ill, w_ill_n;
    logic              w_dec_rd, w_dec_wr, w_dec_ill, w_dec_md, w_hold, w_accept;
    assign w_hold      = r_valid && b.out_stall;
    assign b.in_ready  = !rst && r_state == IDLE && !w_hold;
    assign w_accept    = b.in_valid && b.in_ready && !b.flush;
    assign b.out_valid = r_valid;
    assign b.out_op    = r_op;
    assign b.out_mem_rd  = r_rd;
    assign b.out_mem_wr  = r_wr;
    assign b.out_illegal = r_ill;
    assign b.stall_req   = r_state == MULTI;
    always_comb begin
        w_dec_op  = '0;
        w_dec_rd  = 1'b0;
        w_dec_wr  = 1'b0;
        w_dec_ill = 1'b0;
        w_dec_md  = 1'b0;
        if (b.in_opcode == OPC_W'('h2)) begin
            case (b.in_funct)
                FUNCT_W'('h20): w_dec_op = OP_W'('h3);
                FUNCT_W'('h24): w_dec_op = OP_W'('h5);
                FUNCT_W'('h25): w_dec_op = OP_W'('h2);
                FUNCT_W'('h14): w_dec_op = OP_W'('h4);
                FUNCT_W'('h08): w_dec_op = OP_W'('hB);
                FUNCT_W'('h21): begin w_dec_op = OP_W'('h3); w_dec_rd = 1'b1; end
                FUNCT_W'('h27): w_dec_op = OP_W'('hA);
                FUNCT_W'('h2A): w_dec_op = OP_W'('h8);
                FUNCT_W'('h2B): w_dec_op = OP_W'('h9);
                FUNCT_W'('h00): w_dec_op = OP_W'('h6);
                FUNCT_W'('h02): w_dec_op = OP_W'('h7);
                FUNCT_W'('h13): begin w_dec_op = OP_W'('h3); w_dec_wr = 1'b1; end
                FUNCT_W'('h18): begin w_dec_op = OP_W'('hC); w_dec_md = 1'b1; end
                FUNCT_W'('h1A): begin w_dec_op = OP_W'('hD); w_dec_md = 1'b1; end
                default:        w_dec_ill = 1'b1;
            endcase
        end else begin
            case (b.in_opcode)
                OPC_W'('hB): w_dec_op = OP_W'('h1);
                OPC_W'('h4): w_dec_op = OP_W'('h3);
                OPC_W'('h5): w_dec_op = OP_W'('h4);
                OPC_W'('h7): w_dec_op = OP_W'('h5);
                OPC_W'('h3): w_dec_op = OP_W'('h2);
                default:     w_dec_ill = 1'b1;
            endcase
        end
    end
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_valid_n = r_valid;
        w_op_n    = r_op;
        w_rd_n    = r_rd;
        w_wr_n    = r_wr;
        w_ill_n   = r_ill;
        w_md_op_n = r_md_op;
        if (b.flush) begin
            w_state_n = IDLE;
            w_cnt_n   = '0;
            w_valid_n = 1'b0;
            w_rd_n    = 1'b0;
            w_wr_n    = 1'b0;
            w_ill_n   = 1'b0;
        end else if (r_state == MULTI) begin
            // a finished mult/div waits at count 0 while the output is held
            if (r_cnt != '0) w_cnt_n = r_cnt - 1'b1;
            else if (!w_hold) begin
                w_state_n = IDLE;
                w_valid_n = 1'b1;
                w_op_n    = r_md_op;
                w_rd_n    = 1'b0;
                w_wr_n    = 1'b0;
                w_ill_n   = 1'b0;
            end
        end else if (w_accept) begin
            w_valid_n = !w_dec_md;
            w_rd_n    = w_dec_rd;
            w_wr_n    = w_dec_wr;
            w_ill_n   = w_dec_ill;
            w_op_n    = w_dec_md ? r_op : w_dec_op;
            w_md_op_n = w_dec_md ? w_dec_op : r_md_op;
            w_state_n = w_dec_md ? MULTI : IDLE;
            w_cnt_n   = w_dec_md ? CNT_W'(MULDIV_LAT - 2) : r_cnt;
        end else if (!w_hold) begin
            w_valid_n = 1'b0;
            w_rd_n    = 1'b0;
            w_wr_n    = 1'b0;
            w_ill_n   = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_op    <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_ill   <= 1'b0;
            r_md_op <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_valid <= w_valid_n;
            r_op    <= w_op_n;
            r_rd    <= w_rd_n;
            r_wr    <= w_wr_n;
            r_ill   <= w_ill_n;
            r_md_op <= w_md_op_n;
        end
    end
`ifdef ALU_CTRL_PERF_EN
    logic [15:0] r_issued, r_stalls;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issued <= '0;
            r_stalls <= '0;
        end else begin
            if (w_accept && r_issued != 16'hFFFF) r_issued <= r_issued + 1'b1;
            if ((r_state == MULTI || w_hold) && r_stalls != 16'hFFFF) r_stalls <= r_stalls + 1'b1;
        end
    end
    assign b.perf_issued = r_issued;
    assign b.perf_stalls = r_stalls;
`else
    assign b.perf_issued = '0;
    assign b.perf_stalls = '0;
`endif
endmodule

// File: doc/alu_ctrl_pipe.md
Name: alu_ctrl_pipe

Overview:
- Parametrised, registered successor to the combinational ALU-control decoder.
- Sits at the ID/EX boundary. Decodes opcode/funct into ALU operation and memory read/write strobes, then registers them with a valid/ready handshake.
- Adds multi-cycle mult/div sequencing with a stall request, plus flush and downstream-stall handling. The pipeline uses it in place of the plain decoder.

Parameters:
OPC_W, 4, opcode field width
FUNCT_W, 6, funct field width
OP_W, 5, ALU operation code width
MULDIV_LAT, 4, total cycles from accept to out_valid for mult/div (min 2)
CNT_W, 3, width of the mult/div countdown counter (must hold MULDIV_LAT-1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  decoded instruction present
in_opcode  in  OPC_W  opcode field
in_funct  in  FUNCT_W  funct field (used only when opcode = 4'h2)
in_ready  out  1  block can accept this cycle
flush  in  1  synchronous pipeline flush
out_stall  in  1  downstream cannot take output; hold registers
out_valid  out  1  registered control word valid
out_op  out  OP_W  ALU operation
out_mem_rd  out  1  memory read strobe
out_mem_wr  out  1  memory write strobe
out_illegal  out  1  unrecognised opcode/funct
stall_req  out  1  high while a mult/div is in progress
perf_issued  out  16  issued-op count (ALU_CTRL_PERF_EN only)
perf_stalls  out  16  stall cycle count (ALU_CTRL_PERF_EN only)

Behaviour:
Reset:
- rst asserted (any time, including mid mult/div): all outputs 0 and state IDLE; the counter is cleared.
Decode table:
- Opcode: 4'hB->1; 4'h4->3; 4'h5->4; 4'h7->5; 4'h3->2.
- 4'h2 (R-type), by funct: 0x20->3; 0x24->5; 0x25->2; 0x14->4; 0x08->0xB; 0x21->3 with mem_rd=1; 0x27->0xA; 0x2A->8; 0x2B->9; 0x00->6; 0x02->7; 0x13->3 with mem_wr=1.
- New R-type ops: 0x18 (mult)->0xC, multi-cycle; 0x1A (div)->0xD, multi-cycle.
- Any other opcode or funct: op=0, rd=wr=0, illegal=1.
- Operation codes are zero-extended to OP_W.
Handshake:
- in_ready = (state==IDLE) && !(out_valid && out_stall).
- Accept = in_valid && in_ready && !flush.
States:
- IDLE: a single-cycle accept loads the output regs and raises out_valid on the next edge (latency 1). A mult/div accept clears out_valid, loads the counter with MULDIV_LAT-2 and moves to MULTI. No accept and no stall clears out_valid.
- MULTI: stall_req=1 and in_ready=0. The counter decrements each cycle. At 0, the control word loads, out_valid goes high and the state returns to IDLE. Total latency is exactly MULDIV_LAT cycles.
Downstream stall:
- out_valid && out_stall holds every output register unchanged.
- No accept while held.
- MULTI keeps counting; if it completes while the output is held, it waits in MULTI with counter 0 until the stall drops.
Flush:
- Highest priority after rst.
- Clears out_valid, out_mem_rd, out_mem_wr and out_illegal, aborts MULTI to IDLE and drops any same-cycle input.
- Overrides out_stall.
Other:
- Back-to-back single-cycle ops give one output per cycle.
- The mem_rd/mem_wr strobes are only ever high together with out_valid.

Optional Feature:
ALU_CTRL_PERF_EN
- Defined: two 16-bit saturating counters.
  - perf_issued increments on each accept.
  - perf_stalls increments each cycle stall_req=1 or the output is held.
  - Both stop at 0xFFFF. Both clear on rst only, not on flush.
- Undefined: both ports are driven constant 0 and no counter flops exist.

Test Plan:
- Reset mid-MULTI (rst pulsed 2 cycles after a mult accept) -> all outputs 0, in_ready=1 the cycle after rst deasserts.
- Opcode 4'h2 funct 0x21, then funct 0x13 on consecutive cycles -> out_op=3 with rd=1, then out_op=3 with wr=1, out_valid continuous.
- Mult (funct 0x18), MULDIV_LAT=4 -> stall_req=1 for 3 cycles, in_ready=0, out_op=0xC valid exactly 4 edges after accept.
- out_stall=1 with out_valid=1 and new in_valid (opcode 4'h5) -> output frozen and in_ready=0; on release, out_op=4 next cycle.
- Flush during MULTI together with in_valid -> out_valid=0, state IDLE, input dropped, no 0xC output.
- Opcode 4'h9 or funct 0x3F -> out_illegal=1, out_op=0. With ALU_CTRL_PERF_EN, 70000 accepts -> perf_issued=0xFFFF.
